// File: rtl/board_run_control.sv
// board_run_control: conditions operator controls and gates the datapath clock enable via a run/halt/step FSM with breakpoint
module board_run_control #(
  parameter int DEBOUNCE_CYCLES = 25000,
  parameter int CNT_WIDTH       = 15
) (
  input  logic        i_oszClk,
  input  logic        i_resetn,
  input  logic        i_btnStep,
  input  logic        i_swInstrNCycle,
  input  logic        i_swStepNRun,
  input  logic        i_swEnableBreakpoint,
  input  logic [15:0] i_breakpointAddress,
  input  logic [15:0] i_pc,
  input  logic        i_instrBoundary,
  output logic        o_clkEnable,
  output logic        o_halted,
  output logic        o_breakHit,
  output logic [1:0]  o_state
);
  typedef enum logic [1:0] {HALT = 2'd0, RUN = 2'd1, STEP_CYCLE = 2'd2, STEP_INSTR = 2'd3} state_t;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  logic [3:0] raw, meta_q, sync_q, deb_q, deb_d;
  logic [CNT_WIDTH-1:0] cnt_q [4];
  logic [CNT_WIDTH-1:0] cnt_d [4];
  logic btn_prev_q, btn_prev_d;
  logic break_hit_q, break_hit_d;
  state_t state_q, state_d;
  logic step_pulse, step_n_run, instr_n_cycle, bp_en, bp_hit;
  assign raw = {i_swEnableBreakpoint, i_swStepNRun, i_swInstrNCycle, i_btnStep};
  assign step_pulse    = deb_q[0] & ~btn_prev_q;
  assign instr_n_cycle = deb_q[1];
  assign step_n_run    = deb_q[2];
  assign bp_en         = deb_q[3];
  assign bp_hit        = bp_en && i_instrBoundary && (i_pc == i_breakpointAddress);
  always_comb begin
    btn_prev_d = deb_q[0];
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = (sync_q[i] != deb_q[i] && cnt_q[i] != CNT_MAX) ? cnt_q[i] + 1'b1 : '0;
      deb_d[i] = (sync_q[i] != deb_q[i] && cnt_q[i] == CNT_MAX) ? sync_q[i] : deb_q[i];
    end
  end
  // A breakpoint stop latches until the operator returns to step mode while halted.
  always_comb begin
    state_d     = state_q;
    break_hit_d = break_hit_q;
    case (state_q)
      HALT: begin
        if (!step_n_run && !break_hit_q) state_d = RUN;
        else if (step_pulse && step_n_run) state_d = instr_n_cycle ? STEP_INSTR : STEP_CYCLE;
        if (step_n_run) break_hit_d = 1'b0;
      end
      RUN: begin
        if (step_n_run) state_d = HALT;
        else if (bp_hit) begin
          state_d     = HALT;
          break_hit_d = 1'b1;
        end
      end
      STEP_CYCLE: state_d = HALT;
      default: state_d = i_instrBoundary ? HALT : STEP_INSTR;
    endcase
  end
  always_ff @(posedge i_oszClk or negedge i_resetn) begin
    if (!i_resetn) begin
      meta_q      <= '0;
      sync_q      <= '0;
      deb_q       <= '0;
      btn_prev_q  <= 1'b0;
      break_hit_q <= 1'b0;
      state_q     <= HALT;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      meta_q      <= raw;
      sync_q      <= meta_q;
      deb_q       <= deb_d;
      btn_prev_q  <= btn_prev_d;
      break_hit_q <= break_hit_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
    end
  end
  assign o_clkEnable = state_q != HALT;
  assign o_halted    = state_q == HALT;
  assign o_breakHit  = break_hit_q;
  assign o_state     = state_q;
endmodule

// File: doc/board_run_control.md
Name: board_run_control

Overview:
- Sits between the board's raw buttons/switches and the CPU datapath; conditions the operator controls and decides each oscillator cycle whether the CPU advances.
- Synchronises and debounces the step button and the run/step, instr/cycle and breakpoint-enable switches.
- Runs a run/halt/step state machine with a 16-bit address breakpoint.
- Emits a clock-enable consumed by the datapath, plus halt/breakpoint status for the display.

Parameters:
DEBOUNCE_CYCLES, 25000, consecutive stable cycles needed to accept a new input level (5 ms at 5 MHz)
CNT_WIDTH, 15, width of each debounce counter; must hold DEBOUNCE_CYCLES

Ports:
i_oszClk  input  1  design clock (5 MHz oscillator domain)
i_resetn  input  1  reset, asynchronous assert, active-low
i_btnStep  input  1  raw step button, 1 = pressed
i_swInstrNCycle  input  1  raw switch, 1 = step whole instruction, 0 = single cycle
i_swStepNRun  input  1  raw switch, 1 = step mode, 0 = run
i_swEnableBreakpoint  input  1  raw switch, 1 = breakpoint armed
i_breakpointAddress  input  16  breakpoint compare address
i_pc  input  16  current program counter from datapath
i_instrBoundary  input  1  datapath flag: the current enabled cycle is the last cycle of an instruction
o_clkEnable  output  1  1 = datapath advances this cycle
o_halted  output  1  1 = state machine in HALT
o_breakHit  output  1  sticky: run stopped by breakpoint
o_state  output  2  encoded state: 0 HALT, 1 RUN, 2 STEP_CYCLE, 3 STEP_INSTR

Behaviour:
Clock and reset:
- One clock (i_oszClk); i_resetn is asynchronous, active-low.
- All registers update on rising i_oszClk.
- Reset values:
  - synchroniser and debounced levels = 0
  - counters = 0
  - state = HALT
  - o_clkEnable = 0, o_halted = 1, o_breakHit = 0, o_state = 0

Input conditioning:
- Each raw input passes through a 2-FF synchroniser.
- Debounce per input:
  - if the synchronised value equals the debounced value, the counter clears;
  - otherwise the counter increments;
  - when the counter reaches DEBOUNCE_CYCLES-1, the debounced value takes the new level and the counter clears.
  - Total latency from a clean raw edge to the debounced change = 2 + DEBOUNCE_CYCLES cycles.
- stepPulse = one-cycle pulse on the rising edge of debounced btnStep. Falling edge produces nothing.

State machine (registered outputs are decoded from the state):
- HALT: o_clkEnable = 0.
  - If debounced stepNRun = 0 and o_breakHit = 0: next state RUN.
  - Else if stepPulse and stepNRun = 1: next state STEP_INSTR if instrNCycle = 1, otherwise STEP_CYCLE.
- RUN: o_clkEnable = 1.
  - If stepNRun = 1: next state HALT.
  - Else if enableBreakpoint = 1, i_instrBoundary = 1 and i_pc == i_breakpointAddress: next state HALT and set o_breakHit.
  - The instruction at the boundary cycle completes; the halt takes effect in the following cycle.
- STEP_CYCLE: o_clkEnable = 1 for exactly one cycle, then HALT.
- STEP_INSTR: o_clkEnable = 1 each cycle until and including a cycle with i_instrBoundary = 1, then HALT.
  - The breakpoint is ignored in this state.
  - Switch changes mid-step are ignored until HALT is reached.
- o_breakHit clears only in HALT while debounced stepNRun = 1. The operator must flip to step and back to resume run.

Boundary conditions:
- stepPulse outside HALT is dropped, not queued.
- stepPulse in run mode (stepNRun = 0) is ignored.
- Breakpoint compare is exact over all 16 bits.
- Reset mid-step aborts immediately to HALT with o_clkEnable = 0.
- If the breakpoint address equals the pc at the instant RUN is entered, the match triggers only at that instruction's boundary.

Test Plan:
(Debounce checks use DEBOUNCE_CYCLES = 4; later scenarios rely on the same value.)
- Reset held low, then released with all inputs 0 -> o_halted = 1, o_breakHit = 0, o_state = 0 and o_clkEnable = 0 until the first debounced inputs settle. With stepNRun = 0 and o_breakHit = 0 the block then leaves HALT and enters RUN, so o_clkEnable = 1, o_halted = 0, o_state = 1.
- Debounce: i_btnStep 1 for 3 cycles then 0 -> no step. Held 1 for ≥6 cycles in HALT with stepNRun = 1, instrNCycle = 0 -> exactly one cycle of o_clkEnable = 1, o_state = 2 then 0.
- Instruction step: stepNRun = 1, instrNCycle = 1, press; i_instrBoundary pulses on the 4th enabled cycle -> o_clkEnable high for exactly 4 cycles, then o_halted = 1.
- Run and breakpoint: stepNRun = 0, enable = 1, bp = 16'h0012; pc = 16'h0012 with i_instrBoundary = 1 -> next cycle o_clkEnable = 0, o_halted = 1, o_breakHit = 1.
  - Flipping stepNRun to 0 again does not restart the run.
  - stepNRun 1 then 0 -> o_breakHit clears and RUN resumes.
- Step press during RUN -> no state change, no extra enable pulse. Breakpoint enable = 0 with a matching pc -> run continues.
- Reset asserted during STEP_INSTR -> o_clkEnable = 0 and o_state = 0 immediately (asynchronous), no pulse after release.
